// File: rtl/dcache_line_memory.sv
// Line-granular backing memory for the data cache: one request at a time,
// fixed LATENCY-edge access delay, single-cycle ack with registered read data.
module dcache_line_memory #(
    parameter int LINES   = 512,
    parameter int LATENCY = 10
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         enable_i,
    input  logic         write_i,
    input  logic [31:0]  addr_i,
    input  logic [255:0] data_i,
    output logic         ack_o,
    output logic [255:0] data_o
);
    localparam int IDX_W = $clog2(LINES);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [IDX_W-1:0]   idx_q;
    logic               wr_q;
    logic [255:0]       wdata_q;
    logic               capture, done;

    logic [255:0] mem [LINES];

    // Only the line index matters; offset and alias bits are dropped.
    logic unused_addr;
    assign unused_addr = ^{addr_i[31:5+IDX_W], addr_i[4:0]};

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: if (enable_i) begin
                capture = 1'b1;
                state_d = BUSY;
            end
            BUSY: if (cnt_q == CNT_LAST) begin
                done    = 1'b1;
                state_d = ACK;
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            ack_o   <= 1'b0;
            data_o  <= '0;
        end else begin
            state_q <= state_d;
            ack_o   <= done;
            if (capture) begin
                idx_q   <= addr_i[5 +: IDX_W];
                wr_q    <= write_i;
                wdata_q <= data_i;
                cnt_q   <= '0;
            end else if (state_q == BUSY && !done) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (done && !wr_q)
                data_o <= mem[idx_q];
        end
    end

    // Array kept out of reset; reset forces IDLE so an aborted write never lands.
    always_ff @(posedge clk_i) begin
        if (done && wr_q)
            mem[idx_q] <= wdata_q;
    end

endmodule
